// File: rtl/plru_pkg.sv
// Shared constants, types and helpers for the tree-PLRU victim controller.
// Defaults describe a 64-set, 8-way cache; modules take the geometry as parameters.
package plru_pkg;

    localparam int unsigned SET_COUNT_DFLT     = 64;
    localparam int unsigned WAY_LVL_COUNT_DFLT = 3;
    localparam int unsigned WAY_COUNT          = 1 << WAY_LVL_COUNT_DFLT;
    localparam int unsigned NODE_COUNT         = WAY_COUNT - 1;
    localparam int unsigned SET_IDX_W          = $clog2(SET_COUNT_DFLT);
    localparam int unsigned WAY_IDX_W          = $clog2(WAY_COUNT);

    // Upper bound on ways supported by the one-hot decoder below.
    localparam int unsigned MAX_WAY_COUNT = 64;
    localparam int unsigned MAX_WAY_IDX_W = 6;

    typedef logic [NODE_COUNT-1:0] plru_node_t;

    // One-hot to binary index; a zero mask yields 0.
    function automatic logic [MAX_WAY_IDX_W-1:0] onehot_to_idx(input logic [MAX_WAY_COUNT-1:0] mask);
        logic [MAX_WAY_IDX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < int'(MAX_WAY_COUNT); i++) begin
            if (mask[i]) begin
                idx = idx | MAX_WAY_IDX_W'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/plru_victim_ctrl_tree_calc.sv
// Combinational tree-PLRU step: applies an access to one set's node vector and walks
// the unmodified tree to find its victim. Nodes are stored in preorder (root at bit 0).
module plru_tree_calc
    import plru_pkg::*;
#(
    parameter  int unsigned LVLS  = WAY_LVL_COUNT_DFLT,
    localparam int unsigned WAYS  = 1 << LVLS,
    localparam int unsigned NODES = WAYS - 1
) (
    input  logic [NODES-1:0] old_nodes,
    input  logic [WAYS-1:0]  access_mask,
    output logic [NODES-1:0] new_nodes_c,
    output logic [LVLS-1:0]  victim_way_c,
    output logic [WAYS-1:0]  victim_mask_c
);

    // Point every node on the path to 'way' away from it; a right child sits 2^(depth-1) after its parent.
    function automatic logic [NODES-1:0] touch(input logic [NODES-1:0] nodes, input logic [LVLS-1:0] way);
        logic [NODES-1:0] res;
        logic [LVLS-1:0]  idx;
        logic             dir;
        res = nodes;
        idx = '0;
        for (int l = 0; l < int'(LVLS); l++) begin
            dir      = way[LVLS-1-l];
            res[idx] = ~dir;
            idx      = dir ? idx + LVLS'(1 << (LVLS - 1 - l)) : idx + LVLS'(1);
        end
        return res;
    endfunction

    function automatic logic [LVLS-1:0] walk(input logic [NODES-1:0] nodes);
        logic [LVLS-1:0] way;
        logic [LVLS-1:0] idx;
        logic            dir;
        way = '0;
        idx = '0;
        for (int l = 0; l < int'(LVLS); l++) begin
            dir             = nodes[idx];
            way[LVLS-1-l]   = dir;
            idx             = dir ? idx + LVLS'(1 << (LVLS - 1 - l)) : idx + LVLS'(1);
        end
        return way;
    endfunction

    always_comb begin
        new_nodes_c = old_nodes;
        for (int w = 0; w < int'(WAYS); w++) begin
            if (access_mask[w]) begin
                new_nodes_c = touch(new_nodes_c, LVLS'(w));
            end
        end
        victim_way_c  = walk(old_nodes);
        victim_mask_c = WAYS'(1) << victim_way_c;
    end

endmodule

// File: rtl/plru_victim_ctrl.sv
// Per-set tree-PLRU state owner: records hit touches and grants victims over valid/ready.
// Optional macro PLRU_VICTIM_INVALID_FIRST_EN: prefer the lowest invalid way over the PLRU walk.
module plru_victim_ctrl
    import plru_pkg::*;
#(
    parameter  int unsigned SET_COUNT     = SET_COUNT_DFLT,
    parameter  int unsigned WAY_LVL_COUNT = WAY_LVL_COUNT_DFLT,
    localparam int unsigned WAY_CNT       = 1 << WAY_LVL_COUNT,
    localparam int unsigned NODE_CNT      = WAY_CNT - 1,
    localparam int unsigned SET_W         = $clog2(SET_COUNT),
    localparam int unsigned WAY_W         = WAY_LVL_COUNT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               touch_vld_i,
    input  logic [SET_W-1:0]   touch_set_i,
    input  logic [WAY_CNT-1:0] touch_way_mask_i,
    input  logic               victim_req_vld_i,
    output logic               victim_req_rdy_o,
    input  logic [SET_W-1:0]   victim_req_set_i,
`ifdef PLRU_VICTIM_INVALID_FIRST_EN
    input  logic [WAY_CNT-1:0] victim_req_inv_mask_i,
`endif
    output logic               victim_resp_vld_o,
    input  logic               victim_resp_rdy_i,
    output logic [WAY_W-1:0]   victim_resp_way_o,
    output logic [WAY_CNT-1:0] victim_resp_mask_o
);

    if ((SET_COUNT < 2) || ((SET_COUNT & (SET_COUNT - 1)) != 0)) begin : g_bad_set_count
        $error("plru_victim_ctrl: SET_COUNT must be a power of two and at least 2");
    end
    if ((WAY_LVL_COUNT < 1) || (WAY_LVL_COUNT > MAX_WAY_IDX_W)) begin : g_bad_lvl_count
        $error("plru_victim_ctrl: WAY_LVL_COUNT out of supported range");
    end

    logic [NODE_CNT-1:0] state_q [SET_COUNT];
    logic                resp_vld_q;
    logic [WAY_W-1:0]    resp_way_q;
    logic [WAY_CNT-1:0]  resp_mask_q;

    logic                accept_c;
    logic                touch_hit_c;
    logic [WAY_CNT-1:0]  touch_access_c;
    logic [NODE_CNT-1:0] touch_nodes_c;
    logic [NODE_CNT-1:0] req_base_c;
    logic [NODE_CNT-1:0] alloc_nodes_c;
    logic [WAY_W-1:0]    plru_way_c;
    logic [WAY_CNT-1:0]  plru_mask_c;
    logic [WAY_W-1:0]    alloc_way_c;
    logic [WAY_CNT-1:0]  alloc_mask_c;
    logic [WAY_W-1:0]    touch_vict_way_unused;
    logic [WAY_CNT-1:0]  touch_vict_mask_unused;

    // Single-entry output register: a new request fits whenever the slot is empty or draining.
    assign victim_req_rdy_o = !rst && (!resp_vld_q || victim_resp_rdy_i);
    assign accept_c         = victim_req_vld_i && victim_req_rdy_o;
    assign touch_hit_c      = touch_vld_i && (touch_set_i == victim_req_set_i);
    assign touch_access_c   = touch_vld_i ? touch_way_mask_i : '0;

    plru_tree_calc #(.LVLS(WAY_LVL_COUNT)) u_touch_calc (
        .old_nodes     (state_q[touch_set_i]),
        .access_mask   (touch_access_c),
        .new_nodes_c   (touch_nodes_c),
        .victim_way_c  (touch_vict_way_unused),
        .victim_mask_c (touch_vict_mask_unused)
    );

    // Forward a same-set touch so the victim never lands on the way just hit.
    assign req_base_c = touch_hit_c ? touch_nodes_c : state_q[victim_req_set_i];

    plru_tree_calc #(.LVLS(WAY_LVL_COUNT)) u_victim_calc (
        .old_nodes     (req_base_c),
        .access_mask   (alloc_mask_c),
        .new_nodes_c   (alloc_nodes_c),
        .victim_way_c  (plru_way_c),
        .victim_mask_c (plru_mask_c)
    );

`ifdef PLRU_VICTIM_INVALID_FIRST_EN
    logic [WAY_CNT-1:0] inv_low_c;

    assign inv_low_c = victim_req_inv_mask_i & (~victim_req_inv_mask_i + WAY_CNT'(1));

    always_comb begin
        alloc_mask_c = plru_mask_c;
        alloc_way_c  = plru_way_c;
        if (|victim_req_inv_mask_i) begin
            alloc_mask_c = inv_low_c;
            alloc_way_c  = WAY_W'(onehot_to_idx(MAX_WAY_COUNT'(inv_low_c)));
        end
    end
`else
    always_comb begin
        alloc_mask_c = plru_mask_c;
        alloc_way_c  = plru_way_c;
    end
`endif

    // On a same-set collision the allocation result already contains the touch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < int'(SET_COUNT); s++) begin
                state_q[s] <= '0;
            end
        end else begin
            if (touch_vld_i && !(accept_c && touch_hit_c)) begin
                state_q[touch_set_i] <= touch_nodes_c;
            end
            if (accept_c) begin
                state_q[victim_req_set_i] <= alloc_nodes_c;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            resp_vld_q  <= 1'b0;
            resp_way_q  <= '0;
            resp_mask_q <= '0;
        end else if (accept_c) begin
            resp_vld_q  <= 1'b1;
            resp_way_q  <= alloc_way_c;
            resp_mask_q <= alloc_mask_c;
        end else if (victim_resp_rdy_i) begin
            resp_vld_q  <= 1'b0;
        end
    end

    assign victim_resp_vld_o  = resp_vld_q;
    assign victim_resp_way_o  = resp_way_q;
    assign victim_resp_mask_o = resp_mask_q;

    touch_onehot_a: assert property (@(posedge clk) disable iff (rst)
        touch_vld_i |-> $onehot0(touch_way_mask_i))
        else $error("plru_victim_ctrl: multi-hot touch_way_mask_i");

endmodule

// File: tb/tb_plru_victim_ctrl.sv
// Bench for plru_victim_ctrl (4 sets, 8 ways): constant vector tables plus a heap-indexed
// reference tree feeding a response scoreboard.
module tb_plru_victim_ctrl;

    localparam int unsigned SETS  = 4;
    localparam int unsigned LVLS  = 3;
    localparam int unsigned WAYS  = 8;
    localparam int unsigned SET_W = 2;

    logic             clk;
    logic             rst;
    logic             touch_vld;
    logic [SET_W-1:0] touch_set;
    logic [WAYS-1:0]  touch_mask;
    logic             req_vld;
    logic             req_rdy;
    logic [SET_W-1:0] req_set;
    logic [WAYS-1:0]  inv_mask;
    logic             resp_vld;
    logic             resp_rdy;
    logic [LVLS-1:0]  resp_way;
    logic [WAYS-1:0]  resp_mask;

    plru_victim_ctrl #(.SET_COUNT(SETS), .WAY_LVL_COUNT(LVLS)) dut (
        .clk                   (clk),
        .rst                   (rst),
        .touch_vld_i           (touch_vld),
        .touch_set_i           (touch_set),
        .touch_way_mask_i      (touch_mask),
        .victim_req_vld_i      (req_vld),
        .victim_req_rdy_o      (req_rdy),
        .victim_req_set_i      (req_set),
`ifdef PLRU_VICTIM_INVALID_FIRST_EN
        .victim_req_inv_mask_i (inv_mask),
`endif
        .victim_resp_vld_o     (resp_vld),
        .victim_resp_rdy_i     (resp_rdy),
        .victim_resp_way_o     (resp_way),
        .victim_resp_mask_o    (resp_mask)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference tree in heap order: node n has children 2n (left) and 2n+1 (right); leaves 8..15.
    bit [15:0] m_tree [SETS];
    bit        m_pend;
    int        sb_q[$];
    int        n_cmp;
    int        n_err;

    typedef struct {
        int req_set;
        int exp_way;
    } vec_t;

    function automatic int m_victim(input int s);
        int n;
        n = 1;
        for (int l = 0; l < int'(LVLS); l++) n = 2 * n + int'(m_tree[s][n]);
        return n - int'(WAYS);
    endfunction

    function automatic void m_access(input int s, input int w);
        int n;
        n = w + int'(WAYS);
        while (n > 1) begin
            m_tree[s][n / 2] = (n % 2 == 0);
            n = n / 2;
        end
    endfunction

    function automatic int low_idx(input logic [WAYS-1:0] m);
        for (int i = 0; i < int'(WAYS); i++) if (m[i]) return i;
        return -1;
    endfunction

    task automatic check(input string name, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    task automatic model_clear();
        for (int s = 0; s < int'(SETS); s++) m_tree[s] = '0;
        sb_q.delete();
        m_pend = 1'b0;
    endtask

    // One clock: check outputs against the scoreboard, drive inputs, advance the model, wait.
    task automatic step(input bit tv, input int ts, input logic [WAYS-1:0] tm,
                        input bit rv, input int rs, input logic [WAYS-1:0] im, input bit rr);
        bit exp_rdy;
        int w;
        check("resp_vld", int'(resp_vld), int'(m_pend));
        if (m_pend) begin
            check("sb_way", int'(resp_way), sb_q[0]);
            check("sb_mask", int'(resp_mask), 1 << sb_q[0]);
        end
        touch_vld  = tv;
        touch_set  = SET_W'(ts);
        touch_mask = tm;
        req_vld    = rv;
        req_set    = SET_W'(rs);
        inv_mask   = im;
        resp_rdy   = rr;
        #1;
        exp_rdy = !m_pend || rr;
        check("req_rdy", int'(req_rdy), int'(exp_rdy));
        if (m_pend && rr) begin
            void'(sb_q.pop_front());
            m_pend = 1'b0;
        end
        if (tv && tm != '0) m_access(ts, low_idx(tm));
        if (rv && exp_rdy) begin
`ifdef PLRU_VICTIM_INVALID_FIRST_EN
            w = (im != '0) ? low_idx(im) : m_victim(rs);
`else
            w = m_victim(rs);
`endif
            m_access(rs, w);
            sb_q.push_back(w);
            m_pend = 1'b1;
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, '0, 0, 0, '0, 1);
    endtask

    task automatic check_resp(input string name, input int exp_way);
        check({name, "_vld"}, int'(resp_vld), 1);
        check({name, "_way"}, int'(resp_way), exp_way);
        check({name, "_mask"}, int'(resp_mask), 1 << exp_way);
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        touch_vld  = 1'b0;
        touch_set  = '0;
        touch_mask = '0;
        req_vld    = 1'b0;
        req_set    = '0;
        inv_mask   = '0;
        resp_rdy   = 1'b1;
        model_clear();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_vld", int'(resp_vld), 0);
        check("rst_way", int'(resp_way), 0);
        check("rst_mask", int'(resp_mask), 0);
        check("rst_rdy", int'(req_rdy), 1);
    endtask

    initial begin
        vec_t t1 [8];
        int   tm_i;
        t1 = '{'{0, 0}, '{0, 4}, '{0, 2}, '{0, 6}, '{0, 1}, '{0, 5}, '{0, 3}, '{0, 7}};
        n_cmp = 0;
        n_err = 0;

        // Back-to-back victims on a fresh set sweep the ways in PLRU order.
        do_reset();
        for (int i = 0; i < 8; i++) begin
            step(0, 0, '0, 1, t1[i].req_set, '0, 1);
            check_resp("t1", t1[i].exp_way);
        end
        idle(1);

        // Touching every way in order leaves way 0 as least recent.
        for (int w = 0; w < int'(WAYS); w++) step(1, 1, WAYS'(1) << w, 0, 0, '0, 1);
        step(0, 0, '0, 1, 1, '0, 1);
        check_resp("t2", 0);
        idle(1);

        // Backpressure: response holds, request blocked, then the next PLRU way.
        do_reset();
        step(0, 0, '0, 1, 0, '0, 0);
        check_resp("t3_first", 0);
        for (int i = 0; i < 4; i++) begin
            step(0, 0, '0, 1, 0, '0, 0);
            check_resp("t3_hold", 0);
            check("t3_rdy", int'(req_rdy), 0);
        end
        step(0, 0, '0, 1, 0, '0, 1);
        check_resp("t3_next", 4);
        idle(1);

        // Same-cycle touch is forwarded into the victim choice.
        do_reset();
        step(1, 2, 8'h01, 1, 2, '0, 1);
        check_resp("t4_fwd", 4);
        step(0, 0, '0, 1, 2, '0, 1);
        check_resp("t4_next", 2);
        idle(1);

        // Random traffic on set 0 must not disturb set 3.
        for (int i = 0; i < 300; i++) begin
            tm_i = int'($urandom_range(0, 8));
            step(1'($urandom_range(0, 1)), 0, (tm_i == 8) ? '0 : (WAYS'(1) << tm_i),
                 1'($urandom_range(0, 1)), 0, '0, 1'($urandom_range(0, 1)));
        end
        idle(2);
        step(0, 0, '0, 1, 3, '0, 1);
        check_resp("t5_indep", 0);
        idle(1);

        // Reset while a response is pending drops it.
        step(0, 0, '0, 1, 0, '0, 0);
        check("t5_pend", int'(resp_vld), 1);
        rst = 1'b1;
        #1;
        check("t5_rst_drop", int'(resp_vld), 0);
        model_clear();
        @(negedge clk);
        rst = 1'b0;
        idle(3);
        check("t5_after_rst", int'(resp_vld), 0);

`ifdef PLRU_VICTIM_INVALID_FIRST_EN
        // Invalid way wins and counts as a touch for the following PLRU walk.
        do_reset();
        step(0, 0, '0, 1, 0, 8'b0010_0100, 1);
        check_resp("t6_inv", 2);
        step(0, 0, '0, 1, 0, '0, 1);
        check_resp("t6_plru", 4);
        idle(1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
